// File: rtl/demux_pkg.sv
// Purpose: shared types and default sizes for the demux collector.
//   state_e            : collector FSM state (COLLECT gathers beats, HOLD presents a word)
//   DEFAULT_OUT_LENGTH : default width of the collected word
//   DEFAULT_SEL_LENGTH : default width of the bit-index select
package demux_pkg;

    localparam int unsigned DEFAULT_OUT_LENGTH = 16;
    localparam int unsigned DEFAULT_SEL_LENGTH = 4;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

endpackage

// File: rtl/demux_collector_if.sv
// Purpose: beat/word handshake bundle between a producer/consumer and the collector.
//   flush     : synchronous discard of the partial or held word
//   in_valid  : in/sel beat valid          in_ready  : collector takes a beat
//   in        : serial data bit            sel       : destination bit index
//   out_valid : out_word is complete       out_ready : consumer takes out_word
//   out_word  : collected word             fill_mask : indices written so far
interface demux_collector_if
    import demux_pkg::*;
#(
    parameter int unsigned OUT_LENGTH = DEFAULT_OUT_LENGTH,
    parameter int unsigned SEL_LENGTH = DEFAULT_SEL_LENGTH
) ();

    logic                  flush;
    logic                  in_valid;
    logic                  in;
    logic [SEL_LENGTH-1:0] sel;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_LENGTH-1:0] out_word;
    logic [OUT_LENGTH-1:0] fill_mask;

    modport master (
        output flush, in_valid, in, sel, out_ready,
        input  in_ready, out_valid, out_word, fill_mask
    );

    modport slave (
        input  flush, in_valid, in, sel, out_ready,
        output in_ready, out_valid, out_word, fill_mask
    );

endinterface

// File: rtl/demux_collector_sel_decoder.sv
// Purpose: turn a bit index into a one-hot write-enable vector, gated by accept.
//   i_sel    : destination bit index
//   i_en     : beat accepted this cycle
//   o_we_c   : one-hot write enable (all zero when i_en is low)
module sel_decoder
    import demux_pkg::*;
#(
    parameter int unsigned OUT_LENGTH = DEFAULT_OUT_LENGTH,
    parameter int unsigned SEL_LENGTH = DEFAULT_SEL_LENGTH
) (
    input  logic [SEL_LENGTH-1:0] i_sel,
    input  logic                  i_en,
    output logic [OUT_LENGTH-1:0] o_we_c
);

    always_comb begin
        o_we_c = '0;
        if (i_en) begin
            o_we_c = OUT_LENGTH'(1) << i_sel;
        end
    end

endmodule

// File: rtl/demux_collector.sv
// Purpose: collect serial bits addressed by sel into a parallel word, then hold
//          the word until the consumer takes it.
//   clk  : clock (rising edge)
//   rstn : asynchronous active-low reset
//   bus  : demux_collector_if slave (beat input, word output, flush)
module demux_collector
    import demux_pkg::*;
#(
    parameter int unsigned OUT_LENGTH = DEFAULT_OUT_LENGTH,
    parameter int unsigned SEL_LENGTH = DEFAULT_SEL_LENGTH
) (
    input  logic             clk,
    input  logic             rstn,
    demux_collector_if.slave bus
);

    // Every index must be addressable and every addressable index must exist.
    if (OUT_LENGTH != (32'd1 << SEL_LENGTH)) begin : g_len_check
        $error("demux_collector: OUT_LENGTH must equal 2**SEL_LENGTH");
    end

    state_e                r_state;
    state_e                w_state_nxt;
    logic [OUT_LENGTH-1:0] r_out_word;
    logic [OUT_LENGTH-1:0] r_fill_mask;
    logic [OUT_LENGTH-1:0] w_we;
    logic                  w_accept;
    logic                  w_complete;
    logic                  w_release;

    // Flush wins over a simultaneous beat, so it also blocks the write enables.
    assign w_accept   = bus.in_valid && (r_state == COLLECT) && !bus.flush;
    assign w_complete = &(r_fill_mask | w_we);
    assign w_release  = (r_state == HOLD) && bus.out_ready;

    sel_decoder #(
        .OUT_LENGTH(OUT_LENGTH),
        .SEL_LENGTH(SEL_LENGTH)
    ) u_sel_decoder (
        .i_sel  (bus.sel),
        .i_en   (w_accept),
        .o_we_c (w_we)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.flush) begin
            w_state_nxt = COLLECT;
        end else begin
            case (r_state)
                COLLECT: if (w_accept && w_complete) w_state_nxt = HOLD;
                HOLD:    if (bus.out_ready)          w_state_nxt = COLLECT;
                default: w_state_nxt = COLLECT;
            endcase
        end
    end

    // Word and fill-mask registers; the word keeps old bits until rewritten.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_word  <= '0;
            r_fill_mask <= '0;
        end else begin
            r_out_word <= (r_out_word & ~w_we) | (w_we & {OUT_LENGTH{bus.in}});
            if (bus.flush || w_release) begin
                r_fill_mask <= '0;
            end else begin
                r_fill_mask <= r_fill_mask | w_we;
            end
        end
    end

    // Handshake flags decode straight from the state flop.
    assign bus.in_ready  = (r_state == COLLECT);
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_word  = r_out_word;
    assign bus.fill_mask = r_fill_mask;

endmodule

// File: tb/tb_demux_collector.sv
// Purpose: directed scoreboard bench for demux_collector.
module tb_demux_collector;

    localparam int unsigned OUT_LENGTH = 16;
    localparam int unsigned SEL_LENGTH = 4;

    logic clk;
    logic rstn;

    int n_cmp;
    int n_err;
    logic [15:0] exp_q[$];

    demux_collector_if #(.OUT_LENGTH(OUT_LENGTH), .SEL_LENGTH(SEL_LENGTH)) bus ();

    demux_collector #(
        .OUT_LENGTH(OUT_LENGTH),
        .SEL_LENGTH(SEL_LENGTH)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every word handshake pops one expected word.
    always @(negedge clk) begin
        if (rstn && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got word %h expected none", bus.out_word);
            end else begin
                chk("sb_out_word", 32'(bus.out_word), 32'(exp_q.pop_front()));
                chk("sb_fill_full", 32'(bus.fill_mask), 32'h0000_FFFF);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int s, input logic b);
        bus.in_valid = 1'b1;
        bus.sel      = 4'(s);
        bus.in       = b;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    // Sixteen in-order beats; out_valid must rise exactly after the last one.
    task automatic send_word(input logic [15:0] w, input bit push);
        if (push) exp_q.push_back(w);
        for (int i = 0; i < 16; i++) begin
            beat(i, w[i]);
            chk("latency_out_valid", 32'(bus.out_valid), (i == 15) ? 32'd1 : 32'd0);
        end
        if (bus.out_ready) begin
            cyc();
            chk("release_out_valid", 32'(bus.out_valid), 32'd0);
            chk("release_in_ready", 32'(bus.in_ready), 32'd1);
            chk("release_mask", 32'(bus.fill_mask), 32'd0);
            chk("release_word_kept", 32'(bus.out_word), 32'(w));
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_out_word"}, 32'(bus.out_word), 32'd0);
        chk({tag, "_fill_mask"}, 32'(bus.fill_mask), 32'd0);
    endtask

    // Pulse reset between edges: called at posedge+1, finishes at next posedge+1.
    task automatic mid_cycle_reset(input string tag);
        #6;
        rstn = 1'b0;
        #1;
        check_reset_values(tag);
        #1;
        rstn = 1'b1;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] w;
        n_cmp = 0;
        n_err = 0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in        = 1'b0;
        bus.sel       = '0;
        bus.out_ready = 1'b1;
        rstn          = 1'b1;

        // Reset state
        #1 rstn = 1'b0;
        #2 check_reset_values("reset");
        #9 rstn = 1'b1;
        cyc();
        check_reset_values("post_reset");

        // In-order word 0xA5C3, consumer always ready
        send_word(16'hA5C3, 1'b1);

        // Reverse order with overwrite of index 3 before completion
        w = 16'h3C5A;
        exp_q.push_back(16'h3C52);
        for (int i = 15; i >= 1; i--) beat(i, w[i]);
        chk("rev_mask_pending", 32'(bus.fill_mask), 32'h0000_FFFE);
        beat(3, ~w[3]);
        chk("rev_mask_repeat", 32'(bus.fill_mask), 32'h0000_FFFE);
        chk("rev_no_valid", 32'(bus.out_valid), 32'd0);
        beat(0, w[0]);
        chk("rev_valid", 32'(bus.out_valid), 32'd1);
        chk("rev_word", 32'(bus.out_word), 32'h0000_3C52);
        cyc();
        chk("rev_back_collect", 32'(bus.in_ready), 32'd1);

        // Back-pressure: held word ignores beats for 5 cycles
        bus.out_ready = 1'b0;
        send_word(16'h1234, 1'b1);
        bus.in_valid = 1'b1;
        bus.sel      = 4'd0;
        bus.in       = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_word", 32'(bus.out_word), 32'h0000_1234);
            chk("hold_mask", 32'(bus.fill_mask), 32'h0000_FFFF);
        end
        bus.out_ready = 1'b1;
        bus.sel       = 4'd5;
        cyc();
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rel_mask_clear", 32'(bus.fill_mask), 32'd0);
        cyc();
        chk("rel_next_beat", 32'(bus.fill_mask), 32'h0000_0020);
        bus.in_valid = 1'b0;

        // Flush partial word, then flush with an empty mask
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        chk("flush_mask", 32'(bus.fill_mask), 32'd0);
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        chk("flush_idle_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_idle_mask", 32'(bus.fill_mask), 32'd0);

        // 8 beats then flush racing a beat; the beat is dropped
        for (int i = 0; i < 8; i++) beat(i, 1'b1);
        chk("part_mask", 32'(bus.fill_mask), 32'h0000_00FF);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.sel      = 4'd8;
        bus.in       = 1'b1;
        cyc();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_beat_mask", 32'(bus.fill_mask), 32'd0);
        chk("flush_beat_word", 32'(bus.out_word[8]), 32'd0);
        chk("flush_beat_ready", 32'(bus.in_ready), 32'd1);
        send_word(16'hBEEF, 1'b1);

        // Asynchronous reset mid-word and while holding
        for (int i = 0; i < 6; i++) beat(i, 1'b1);
        mid_cycle_reset("rst_midword");
        bus.out_ready = 1'b0;
        send_word(16'h0F0F, 1'b0);
        mid_cycle_reset("rst_hold");
        bus.out_ready = 1'b1;
        send_word(16'h5A5A, 1'b1);

        cyc();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
